final_unit: RTL and testbench



---
 rtl/final_unit_pkg.sv | 10 +
 rtl/final_unit_if.sv | 12 +
 rtl/final_unit_wide_add.sv | 34 +++
 rtl/final_unit.sv | 32 +++
 tb/tb_final_unit.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/final_unit_pkg.sv
// Shared widths and types for the final_unit accumulator and its wide combinational adder.
package final_pkg;

    localparam int A_W = 64;
    localparam int L_W = 129;

    typedef logic [A_W-1:0] a_t;
    typedef logic [L_W-1:0] long_t;

endpackage

// File: rtl/final_unit_if.sv
// Data bundle between final_unit and its user: the accumulator increment, the wide operand and both results.
interface final_unit_if;

    final_pkg::a_t    a;
    final_pkg::long_t long_in;
    final_pkg::a_t    x;
    final_pkg::long_t long_out;

    modport master (output a, output long_in, input x, input long_out);
    modport slave  (input a, input long_in, output x, output long_out);

endinterface

// File: rtl/final_unit_wide_add.sv
// Unsigned L_W-bit + zero-extended A_W-bit adder, built from carry-chained 64-bit slices; carry out is dropped.
module final_wide_add #(
    parameter int L_W = 129,
    parameter int A_W = 64
) (
    input  logic [L_W-1:0] op_long,
    input  logic [A_W-1:0] op_short,
    output logic [L_W-1:0] sum
);

    localparam int SW = 64;
    localparam int NS = (L_W + SW - 1) / SW;

    logic [L_W-1:0] short_ext;
    logic [NS-1:0]  carry;

    assign short_ext = {{(L_W-A_W){1'b0}}, op_short};
    assign carry[0]  = 1'b0;

    // The top slice may be narrower than SW and has no carry out to keep.
    for (genvar g = 0; g < NS; g++) begin : g_slice
        localparam int LO = g * SW;
        localparam int W  = (g == NS - 1) ? (L_W - LO) : SW;

        if (g < NS - 1) begin : g_mid
            assign {carry[g+1], sum[LO +: W]} = {1'b0, op_long[LO +: W]}
                                              + {1'b0, short_ext[LO +: W]}
                                              + (W+1)'(carry[g]);
        end else begin : g_top
            assign sum[LO +: W] = op_long[LO +: W] + short_ext[LO +: W] + W'(carry[g]);
        end
    end

endmodule

// File: rtl/final_unit.sv
// Running 64-bit accumulator with a registered output x and a combinational wide sum long_out = long_in + x.
module final_unit
    import final_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    final_unit_if.slave bus
);

    a_t acc;

    // Wraps modulo 2^A_W; reset only takes effect on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= acc + bus.a;
        end
    end

    assign bus.x = acc;

    final_wide_add #(
        .L_W(L_W),
        .A_W(A_W)
    ) u_wide_add (
        .op_long (bus.long_in),
        .op_short(acc),
        .sum     (bus.long_out)
    );

endmodule

// File: tb/tb_final_unit.sv
// Directed scoreboard bench for final_unit: reset, accumulation, wrap, carry into the upper bits and the combinational path.
module tb_final_unit;
    import final_pkg::*;

    typedef struct packed {
        a_t    x;
        long_t lo;
    } exp_t;

    logic clk;
    logic rst_n;
    final_unit_if bus ();

    final_unit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    exp_t exp_q[$];
    a_t   model_acc;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input long_t obs, input long_t exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one cycle's inputs on the falling edge and records what the next rising edge must produce.
    task automatic applyStimulus(input logic r, input a_t av, input long_t li);
        exp_t e;
        @(negedge clk);
        rst_n       = r;
        bus.a       = av;
        bus.long_in = li;
        model_acc   = r ? model_acc + av : '0;
        e.x         = model_acc;
        e.lo        = li + long_t'(model_acc);
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            checkVal({tag, "_x"}, long_t'(bus.x), long_t'(e.x));
            checkVal({tag, "_long_out"}, bus.long_out, e.lo);
        end
    endtask

    initial begin
        long_t ones;
        long_t p128;
        long_t low64;
        ones      = '1;
        p128      = '0;
        p128[128] = 1'b1;
        low64     = '0;
        low64[63:0] = '1;
        checks    = 0;
        errors    = 0;
        model_acc = '0;
        rst_n       = 1'b0;
        bus.a       = 64'd7;
        bus.long_in = 129'd5;

        // Reset held for two edges with a nonzero increment.
        applyStimulus(1'b0, 64'd7, 129'd5);
        checkOutput("reset0");
        applyStimulus(1'b0, 64'd7, 129'd5);
        checkOutput("reset1");
        checkVal("reset_const_x", long_t'(bus.x), 129'd0);
        checkVal("reset_const_lo", bus.long_out, 129'd5);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 64'd3, 129'd0);
            checkOutput("accum");
        end
        checkVal("accum_const_x", long_t'(bus.x), 129'd12);

        // Combinational path between edges with x held at 12.
        bus.long_in = 129'd100;
        #1 checkVal("comb_100", bus.long_out, 129'd112);
        bus.long_in = p128;
        #1 checkVal("comb_2p128", bus.long_out, p128 + 129'd12);

        // Reset asserted mid-operation: no effect until the edge.
        @(negedge clk);
        rst_n       = 1'b0;
        bus.a       = 64'd5;
        bus.long_in = 129'd0;
        #1 checkVal("midrst_hold_x", long_t'(bus.x), 129'd12);
        checkVal("midrst_hold_lo", bus.long_out, 129'd12);
        model_acc = '0;
        exp_q.push_back('{x: '0, lo: 129'd0});
        checkOutput("midrst_edge");
        applyStimulus(1'b1, 64'd5, 129'd0);
        checkOutput("midrst_release");
        checkVal("midrst_const_x", long_t'(bus.x), 129'd5);

        // Wrap modulo 2^64: 5 -> 1 -> 0 -> 2 -> 1.
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 129'd7);
        checkOutput("wrap_to1");
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 129'd0);
        checkOutput("wrap_to0");
        checkVal("wrap_const_x0", long_t'(bus.x), 129'd0);
        applyStimulus(1'b1, 64'd2, 129'd0);
        checkOutput("wrap_to2");
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 129'd0);
        checkOutput("wrap_back1");
        checkVal("wrap_const_x1", long_t'(bus.x), 129'd1);

        // Carry out of bit 63 and out of the top bit, with x = 1.
        bus.long_in = low64;
        #1 checkVal("carry_bit64", bus.long_out, 129'h1_0000_0000_0000_0000);
        bus.long_in = ones;
        #1 checkVal("carry_allones", bus.long_out, 129'd0);

        // long_in changes on the same edge the accumulator moves.
        applyStimulus(1'b1, 64'd4, 129'd10);
        checkOutput("simul_edge");
        checkVal("simul_const", bus.long_out, 129'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
